// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus types, the
// all-zero bubble word, the fetch FSM state encoding and small helpers.
package if_fetch_pkg;

  localparam int unsigned INST_W       = 32;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned STALL_W      = 6;
  localparam int unsigned STALL_IF_BIT = 1;

  typedef logic [STALL_W-1:0] stall_bus_t;
  typedef logic [ADDR_W-1:0]  inst_addr_bus_t;
  typedef logic [INST_W-1:0]  inst_bus_t;

  localparam inst_bus_t ZERO_WORD = '0;

  typedef enum logic [2:0] {
    S_REQ0 = 3'd0,
    S_REQ1 = 3'd1,
    S_REQ2 = 3'd2,
    S_REQ3 = 3'd3,
    S_LAST = 3'd4,
    S_DONE = 3'd5
  } fetch_state_t;

  // Byte offset from pc requested in a given state (0 outside REQ1..REQ3).
  function automatic inst_addr_bus_t req_offset(input fetch_state_t s);
    case (s)
      S_REQ1:  return ADDR_W'(1);
      S_REQ2:  return ADDR_W'(2);
      S_REQ3:  return ADDR_W'(3);
      default: return ADDR_W'(0);
    endcase
  endfunction

  // State following a granted request.
  function automatic fetch_state_t req_succ(input fetch_state_t s);
    case (s)
      S_REQ0:  return S_REQ1;
      S_REQ1:  return S_REQ2;
      S_REQ2:  return S_REQ3;
      default: return S_LAST;
    endcase
  endfunction

endpackage

// File: rtl/fetch_byte_asm.sv
// Little-endian byte assembler: each shift pushes din into the top byte,
// so after four shifts word = {b3,b2,b1,b0}.
// Ports: clk, rst (sync, active-high), clr (discard partial word),
//        shift (accept din), din (byte in), word_c (word including din).
module fetch_byte_asm
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  output logic [INST_W-1:0] word_c
);

  logic [INST_W-1:0] word;

  // Value the register takes on a shift; also the completed word when
  // din carries the last byte.
  assign word_c = {din, word[INST_W-1:BYTE_W]};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= ZERO_WORD;
    end else if (shift) begin
      word <= word_c;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, reads each instruction as four
// little-endian bytes over a granted byte port, and presents it to IF/ID.
// Ports: clk, rst (sync, active-high); stall_sign (bit1 holds IF);
//        branch_flag/branch_target (EX redirect); mem_grant/mem_rdata and
//        mem_re/mem_addr (byte port); if_pc/if_inst (0 = bubble);
//        if_stall_req (fetch in flight).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_sign,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               mem_grant,
  input  logic [BYTE_W-1:0]  mem_rdata,
  output logic               mem_re,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INST_W-1:0]  if_inst,
  output logic               if_stall_req
);

  fetch_state_t      state, next_state;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              pending;
  logic              granted;
  logic              re_next;
  logic              asm_clr, asm_shift;
  logic [INST_W-1:0] word_c;
  logic              unused_stall;

  assign unused_stall = ^{stall_sign[STALL_W-1:STALL_IF_BIT+1], stall_sign[0]};

  // mem_re is only ever high in a REQ state, so it qualifies the grant.
  assign granted = mem_re & mem_grant;

  fetch_byte_asm u_asm (
    .clk    (clk),
    .rst    (rst),
    .clr    (asm_clr),
    .shift  (asm_shift),
    .din    (mem_rdata),
    .word_c (word_c)
  );

  // Next-state, next-PC and request decode; a redirect overrides everything.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    re_next    = 1'b0;
    asm_clr    = 1'b0;
    asm_shift  = 1'b0;
    if (branch_flag) begin
      next_state = S_REQ0;
      pc_next    = branch_target;
      asm_clr    = 1'b1;
    end else begin
      case (state)
        S_REQ0, S_REQ1, S_REQ2, S_REQ3: begin
          // pending marks the byte granted last cycle, now on mem_rdata.
          asm_shift = pending;
          if (granted) begin
            next_state = req_succ(state);
            re_next    = (req_succ(state) != S_LAST);
          end else begin
            re_next = 1'b1;
          end
        end
        S_LAST: begin
          asm_shift  = 1'b1;
          next_state = S_DONE;
        end
        S_DONE: begin
          if (!stall_sign[STALL_IF_BIT]) begin
            next_state = S_REQ0;
            pc_next    = pc + ADDR_W'(4);
            re_next    = 1'b1;
            asm_clr    = 1'b1;
          end
        end
        default: begin
          next_state = S_REQ0;
          asm_clr    = 1'b1;
        end
      endcase
    end
  end

  // State, PC and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_REQ0;
      pc           <= RESET_PC;
      pending      <= 1'b0;
      mem_re       <= 1'b0;
      mem_addr     <= '0;
      if_pc        <= '0;
      if_inst      <= ZERO_WORD;
      if_stall_req <= 1'b0;
    end else begin
      state        <= next_state;
      pc           <= pc_next;
      pending      <= granted & ~branch_flag;
      mem_re       <= re_next;
      mem_addr     <= pc_next + req_offset(next_state);
      if_stall_req <= (next_state != S_DONE);
      if (next_state == S_DONE) begin
        // Load once on entry; a stalled DONE holds the presented word.
        if (state == S_LAST) begin
          if_inst <= word_c;
          if_pc   <= pc;
        end
      end else begin
        if_inst <= ZERO_WORD;
        if_pc   <= '0;
      end
    end
  end

endmodule
